// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage and IF/ID pipeline register of the
// 16-bit pipelined cpu.
//
// The stage holds the PC and drives instruction memory. Each fetched word is
// latched into IF/ID together with PC+2, which ID uses as its branch base.
// A fetched HLT opcode freezes the PC. Only a redirect or a reset resumes
// fetch.
//
// Optional feature macro: IF_STATS_EN
//   When defined, the stage adds two 32-bit ports, fetch_cnt_o and
//   flush_cnt_o, that count normal IF/ID loads and redirects that squash a
//   valid IF/ID entry.
//
// Flow control:
//   This stage has no valid/ready handshake. stall_i acts as the downstream
//   "not ready" signal: while it is high, the PC, IF/ID and the halt state all
//   hold. valid_ID_o marks whether IF/ID carries a real instruction (1) or a
//   bubble (0).
//
// Per-edge priority: reset > redirect > stall > halted > normal fetch.
// ---------------------------------------------------------------------------
module if_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [15:0] redirect_pc_i,
   output logic [15:0] imem_addr_o,
   input  logic [15:0] imem_data_i,
   output logic [15:0] pc_o,
   output logic [15:0] instr_IF_o,
   output logic [15:0] instr_ID_o,
   output logic [15:0] pc_plus2_ID_o,
   output logic        valid_ID_o,
   output logic        halted_o
`ifdef IF_STATS_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   // Fetch FSM: running, or frozen on a fetched HLT. The current state is
   // visible on halted_o.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   fetch_state_t state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  instr_id_q, instr_id_d;
   logic [15:0]  pc_plus2_id_q, pc_plus2_id_d;
   logic         valid_id_q, valid_id_d;
   logic [15:0]  pc_plus2;
   logic [15:0]  redirect_pc_aligned;
   logic         fetch_load;
   logic         flush_event;

   // The PC is always halfword aligned, so the reset value drops bit 0.
   localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

   assign pc_plus2            = pc_q + 16'd2;   // wraps at 2^16 by width
   assign redirect_pc_aligned = {redirect_pc_i[15:1], 1'b0};

   // Next-state logic for the PC, IF/ID and the fetch FSM, in priority order.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_id_d    = instr_id_q;
      pc_plus2_id_d = pc_plus2_id_q;
      valid_id_d    = valid_id_q;
      fetch_load    = 1'b0;
      flush_event   = 1'b0;
      if (redirect_i) begin
         // A redirect also squashes a wrong-path HLT, so fetch resumes.
         pc_d        = redirect_pc_aligned;
         instr_id_d  = 16'h0000;
         valid_id_d  = 1'b0;
         state_d     = ST_RUN;
         flush_event = valid_id_q;
      end else if (stall_i) begin
         // Hold everything.
      end else if (state_q == ST_HALT) begin
         // While halted, IF/ID receives bubbles and the PC stays on the HLT.
         instr_id_d = 16'h0000;
         valid_id_d = 1'b0;
      end else begin
         instr_id_d    = imem_data_i;
         pc_plus2_id_d = pc_plus2;
         valid_id_d    = 1'b1;
         fetch_load    = 1'b1;
         if (imem_data_i[15:12] == HALT_OPCODE) begin
            state_d = ST_HALT;
         end else begin
            pc_d = pc_plus2;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC_ALIGNED;
         instr_id_q    <= 16'h0000;
         pc_plus2_id_q <= 16'h0000;
         valid_id_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_id_q    <= instr_id_d;
         pc_plus2_id_q <= pc_plus2_id_d;
         valid_id_q    <= valid_id_d;
      end
   end

   assign imem_addr_o   = pc_q;
   assign pc_o          = pc_q;
   assign halted_o      = (state_q == ST_HALT);
   assign instr_IF_o    = halted_o ? 16'h0000 : imem_data_i;
   assign instr_ID_o    = instr_id_q;
   assign pc_plus2_ID_o = pc_plus2_id_q;
   assign valid_ID_o    = valid_id_q;

`ifdef IF_STATS_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Event counters. Both wrap naturally at 2^32.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (fetch_load) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (flush_event) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   // Without the statistics feature, the event strobes have no consumer.
   logic unused_stats;
   assign unused_stats = fetch_load ^ flush_event;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: directed testbench for if_stage.
//
// Inputs are driven 1 time unit after each posedge, and outputs are checked
// at the same point. Each step advances exactly one clock.
// ---------------------------------------------------------------------------
module tb_if_stage;

   logic        clk;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [15:0] redirect_pc_i;
   logic [15:0] imem_addr_o;
   logic [15:0] imem_data_i;
   logic [15:0] pc_o;
   logic [15:0] instr_IF_o;
   logic [15:0] instr_ID_o;
   logic [15:0] pc_plus2_ID_o;
   logic        valid_ID_o;
   logic        halted_o;
`ifdef IF_STATS_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   int pass_cnt;
   int total_cnt;

   if_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_addr_o   (imem_addr_o),
      .imem_data_i   (imem_data_i),
      .pc_o          (pc_o),
      .instr_IF_o    (instr_IF_o),
      .instr_ID_o    (instr_ID_o),
      .pc_plus2_ID_o (pc_plus2_ID_o),
      .valid_ID_o    (valid_ID_o),
      .halted_o      (halted_o)
`ifdef IF_STATS_EN
      ,
      .fetch_cnt_o   (fetch_cnt_o),
      .flush_cnt_o   (flush_cnt_o)
`endif
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock edge, then move off the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Directed stimulus sequence.
   initial begin
      pass_cnt      = 0;
      total_cnt     = 0;
      rst_n         = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 16'h0000;
      imem_data_i   = 16'hA123;

      // T1: reset, followed by the first fetch.
      step();
      step();
      chk("rst_pc",       pc_o,          16'h0000);
      chk("rst_valid",    valid_ID_o,    1'b0);
      chk("rst_instr_id", instr_ID_o,    16'h0000);
      chk("rst_pp2",      pc_plus2_ID_o, 16'h0000);
      chk("rst_halted",   halted_o,      1'b0);
      chk("rst_imemaddr", imem_addr_o,   16'h0000);
      chk("rst_instr_if", instr_IF_o,    16'hA123);
      rst_n = 1'b1;
      step();
      chk("t1_instr_id", instr_ID_o,    16'hA123);
      chk("t1_pp2",      pc_plus2_ID_o, 16'h0002);
      chk("t1_pc",       pc_o,          16'h0002);
      chk("t1_valid",    valid_ID_o,    1'b1);

      // Fetch two more words to reach pc=0006.
      imem_data_i = 16'h1111;
      step();
      chk("f2_instr_id", instr_ID_o, 16'h1111);
      chk("f2_pc",       pc_o,       16'h0004);
      imem_data_i = 16'h2222;
      step();
      chk("f3_instr_id", instr_ID_o,    16'h2222);
      chk("f3_pp2",      pc_plus2_ID_o, 16'h0006);
      chk("f3_pc",       pc_o,          16'h0006);

      // T2: stall for three cycles at pc=0006.
      stall_i     = 1'b1;
      imem_data_i = 16'h3333;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_pc",       pc_o,          16'h0006);
         chk("t2_instr_id", instr_ID_o,    16'h2222);
         chk("t2_pp2",      pc_plus2_ID_o, 16'h0006);
         chk("t2_valid",    valid_ID_o,    1'b1);
      end
      stall_i = 1'b0;
      step();
      chk("t2_resume_id", instr_ID_o,    16'h3333);
      chk("t2_resume_pc", pc_o,          16'h0008);
      chk("t2_resume_pp", pc_plus2_ID_o, 16'h0008);

      // T3: redirect with a simultaneous stall; bit 0 of the target is dropped.
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 16'h0041;
      step();
      chk("t3_pc",       pc_o,       16'h0040);
      chk("t3_valid",    valid_ID_o, 1'b0);
      chk("t3_instr_id", instr_ID_o, 16'h0000);
      stall_i = 1'b0;

      // T4: HLT at pc=0010.
      redirect_pc_i = 16'h0010;
      step();
      chk("t4_redir_pc", pc_o, 16'h0010);
      redirect_i  = 1'b0;
      imem_data_i = 16'hF000;
      #1;
      chk("t4_instr_if_pre", instr_IF_o, 16'hF000);
      step();
      chk("t4_instr_id", instr_ID_o,    16'hF000);
      chk("t4_valid",    valid_ID_o,    1'b1);
      chk("t4_halted",   halted_o,      1'b1);
      chk("t4_pc",       pc_o,          16'h0010);
      chk("t4_pp2",      pc_plus2_ID_o, 16'h0012);
      chk("t4_instr_if", instr_IF_o,    16'h0000);
      step();
      chk("t4_bub_valid", valid_ID_o, 1'b0);
      chk("t4_bub_id",    instr_ID_o, 16'h0000);
      chk("t4_bub_if",    instr_IF_o, 16'h0000);
      chk("t4_bub_pc",    pc_o,       16'h0010);
      chk("t4_bub_halt",  halted_o,   1'b1);
      redirect_i    = 1'b1;
      redirect_pc_i = 16'h0020;
      step();
      chk("t4_unhalt",   halted_o,   1'b0);
      chk("t4_unhalt_pc", pc_o,      16'h0020);
      chk("t4_unhalt_if", instr_IF_o, 16'hF000);
      redirect_i  = 1'b0;
      imem_data_i = 16'h4444;
      step();
      chk("t4_post_id", instr_ID_o, 16'h4444);
      chk("t4_post_pc", pc_o,       16'h0022);

      // T5: PC wraps from FFFE to 0000.
      redirect_i    = 1'b1;
      redirect_pc_i = 16'hFFFE;
      step();
      chk("t5_pc_fffe", pc_o, 16'hFFFE);
      redirect_i  = 1'b0;
      imem_data_i = 16'h1234;
      step();
      chk("t5_pc",       pc_o,          16'h0000);
      chk("t5_pp2",      pc_plus2_ID_o, 16'h0000);
      chk("t5_instr_id", instr_ID_o,    16'h1234);
      chk("t5_imemaddr", imem_addr_o,   16'h0000);

      // Mid-operation reset overrides stall and redirect.
      imem_data_i = 16'h5555;
      step();
      chk("mr_pre_pc", pc_o, 16'h0002);
      rst_n         = 1'b0;
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 16'h0100;
      step();
      chk("mr_pc",       pc_o,          16'h0000);
      chk("mr_valid",    valid_ID_o,    1'b0);
      chk("mr_instr_id", instr_ID_o,    16'h0000);
      chk("mr_pp2",      pc_plus2_ID_o, 16'h0000);
`ifdef IF_STATS_EN
      chk("mr_fetch_cnt", fetch_cnt_o, 32'd0);
      chk("mr_flush_cnt", flush_cnt_o, 32'd0);
`endif
      rst_n      = 1'b1;
      stall_i    = 1'b0;
      redirect_i = 1'b0;

`ifdef IF_STATS_EN
      // T6: 5 fetches, 1 stall, and 1 redirect while valid_ID is set.
      imem_data_i = 16'h1000;
      for (int i = 0; i < 5; i++) begin
         step();
      end
      chk("t6_fetch5", fetch_cnt_o, 32'd5);
      stall_i = 1'b1;
      step();
      chk("t6_stall_fetch", fetch_cnt_o, 32'd5);
      stall_i       = 1'b0;
      redirect_i    = 1'b1;
      redirect_pc_i = 16'h0200;
      step();
      chk("t6_fetch_cnt", fetch_cnt_o, 32'd5);
      chk("t6_flush_cnt", flush_cnt_o, 32'd1);
      step();
      chk("t6_flush_bub", flush_cnt_o, 32'd1);
      redirect_i = 1'b0;
`else
      imem_data_i = 16'h6666;
      step();
      chk("post_rst_id", instr_ID_o, 16'h6666);
      chk("post_rst_pc", pc_o,       16'h0002);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
